// File: rtl/sliding_window_3x3_axis_pkg.sv
// Shared constants and types for the 3x3 sliding-window stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default pixel width, the kernel size, the window-index helper
// (pix[r][c] sits in slot 3r+c of the output beat) and the per-pixel
// window metadata carried down the pipeline.
package sliding_window_3x3_axis_pkg;

    localparam int DEF_PIX_W = 32;
    localparam int KSIZE     = 3;
    localparam int WIN_N     = KSIZE * KSIZE;

    // Slot of pixel (row r, column c) inside a flattened window.
    function automatic int win_idx(input int r, input int c);
        return KSIZE * r + c;
    endfunction

    // Per-pixel flags travelling with the pixel through S0/S1.
    typedef struct packed {
        logic win;    // this pixel completes a fully valid window
        logic first;  // first window of the frame
        logic last;   // last window of an output row
    } meta_t;

endpackage

// File: rtl/line_buffer_sdp.sv
// Simple dual-port line RAM, one write port and one enabled read port.
// Latency: 1 cycle read; read-before-write on an address collision.
// Backpressure: none; read data holds while rd_en is low.
//
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_dat   write port
//   rd_en/rd_addr    read request; rd_dat updates only when rd_en
//   rd_dat           registered read data
// Contents are not reset.
module line_buffer_sdp #(
    parameter int DEPTH = 642,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);

    logic [W-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-address read returns the
    // value stored before this cycle's write.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/sliding_window_3x3_axis.sv
// 3x3 neighbourhood generator: padded AXI-Stream raster in, one full window per beat out.
// Latency: 2 cycles from pixel acceptance to m00_axis_tvalid; 1 pixel/clk sustained.
// Backpressure: whole pipeline stalls while the output beat is held; s00_axis_tready drops with it.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   s00_axis_tvalid/tready/tdata/tuser/tlast   padded pixel stream (tuser = start of frame)
//   m00_axis_tvalid/tready/tdata/tstrb/tuser/tlast   window stream; pix[r][c] at [(3r+c)*W +: W],
//                                r=0 oldest row, c=0 leftmost column; tuser = first window of
//                                frame, tlast = last window of an output row
//   err_line_len                 sticky line-length error (only with SLIDING_WINDOW_LINE_CHECK_EN)
// Build option: define SLIDING_WINDOW_LINE_CHECK_EN to check s00_axis_tlast against the line
// length and let an early tlast wrap the column; otherwise tlast is ignored.
module sliding_window_3x3_axis
    import sliding_window_3x3_axis_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = DEF_PIX_W,
    parameter int PAD_W              = 642,
    parameter int PAD_H              = 482
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   s00_axis_tvalid,
    output logic                                   s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]          s00_axis_tdata,
    input  logic                                   s00_axis_tuser,
    input  logic                                   s00_axis_tlast,
    output logic                                   m00_axis_tvalid,
    input  logic                                   m00_axis_tready,
    output logic [WIN_N*C_AXIS_TDATA_WIDTH-1:0]    m00_axis_tdata,
    output logic [WIN_N*C_AXIS_TDATA_WIDTH/8-1:0]  m00_axis_tstrb,
    output logic                                   m00_axis_tuser,
    output logic                                   m00_axis_tlast
`ifdef SLIDING_WINDOW_LINE_CHECK_EN
    ,
    output logic                                   err_line_len
`endif
);

    localparam int W     = C_AXIS_TDATA_WIDTH;
    localparam int COL_W = $clog2(PAD_W);
    localparam int ROW_W = $clog2(PAD_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PAD_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PAD_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic m_vld_q;
    logic adv;
    logic acc;

    assign adv             = !m_vld_q || m00_axis_tready;
    assign s00_axis_tready = adv && resetn;
    assign acc             = s00_axis_tvalid && s00_axis_tready;

    // ------------------------------------------------------------------
    // Raster position of the pixel being accepted
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_q, col_cur;
    logic [ROW_W-1:0] row_q, row_cur;
    logic             col_wrap;
    logic             resync;
    meta_t            s0_meta;

    // tuser pins its pixel to (0,0) regardless of where the counters were.
    always_comb begin
        col_cur       = s00_axis_tuser ? '0 : col_q;
        row_cur       = s00_axis_tuser ? '0 : row_q;
        s0_meta.win   = (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
        s0_meta.first = (row_cur == ROW_TWO) && (col_cur == COL_TWO);
        s0_meta.last  = (col_cur == COL_LAST);
    end

`ifdef SLIDING_WINDOW_LINE_CHECK_EN
    logic line_err;
    logic err_q;

    assign col_wrap     = (col_cur == COL_LAST) || s00_axis_tlast;
    assign line_err     = s00_axis_tlast != (col_cur == COL_LAST);
    assign err_line_len = err_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (acc && line_err) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_tlast;

    assign col_wrap     = (col_cur == COL_LAST);
    assign unused_tlast = s00_axis_tlast;
`endif

    // A tuser arriving anywhere but the expected frame start abandons the
    // interrupted frame: windows not yet in the output register are dropped.
    // A tuser exactly at the wrap point is an ordinary back-to-back frame.
    assign resync = acc && s00_axis_tuser && ((row_q != '0) || (col_q != '0));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else if (acc) begin
            if (col_wrap) begin
                col_q <= '0;
                row_q <= (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col_q <= col_cur + 1'b1;
                row_q <= row_cur;
            end
        end
    end

    // ------------------------------------------------------------------
    // S0: pixel register plus line-buffer reads at the current column
    // ------------------------------------------------------------------
    logic             p0_vld;
    logic [W-1:0]     p0_pix;
    logic [COL_W-1:0] p0_col;
    meta_t            p0_meta;
    logic [W-1:0]     lb0_rd;
    logic [W-1:0]     lb1_rd;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            p0_vld  <= 1'b0;
            p0_pix  <= '0;
            p0_col  <= '0;
            p0_meta <= '0;
        end else if (adv) begin
            p0_vld <= acc;
            if (acc) begin
                p0_pix  <= s00_axis_tdata;
                p0_col  <= col_cur;
                p0_meta <= s0_meta;
            end
        end
    end

    // LB0 holds the previous row: read-before-write at the same column.
    line_buffer_sdp #(.DEPTH(PAD_W), .W(W), .AW(COL_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (acc),
        .wr_addr (col_cur),
        .wr_dat  (s00_axis_tdata),
        .rd_en   (acc),
        .rd_addr (col_cur),
        .rd_dat  (lb0_rd)
    );

    // LB1 holds the row before that. LB0's displaced value is only available
    // one cycle after the read, so it is written back from S1 at the column
    // the pixel was accepted on. The S0 read of the next pixel targets a
    // different column, so the delayed write never shadows it.
    line_buffer_sdp #(.DEPTH(PAD_W), .W(W), .AW(COL_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (adv && p0_vld),
        .wr_addr (p0_col),
        .wr_dat  (lb0_rd),
        .rd_en   (acc),
        .rd_addr (col_cur),
        .rd_dat  (lb1_rd)
    );

    // ------------------------------------------------------------------
    // S1: 3x3 window, shifts left one column per pixel
    // ------------------------------------------------------------------
    logic [WIN_N-1:0][W-1:0] win_q;
    meta_t                   w_meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            win_q  <= '0;
            w_meta <= '0;
        end else if (adv) begin
            w_meta.win   <= p0_vld && p0_meta.win && !resync;
            w_meta.first <= p0_meta.first;
            w_meta.last  <= p0_meta.last;
            if (p0_vld) begin
                for (int r = 0; r < KSIZE; r++) begin
                    win_q[win_idx(r, 0)] <= win_q[win_idx(r, 1)];
                    win_q[win_idx(r, 1)] <= win_q[win_idx(r, 2)];
                end
                win_q[win_idx(0, 2)] <= lb1_rd;
                win_q[win_idx(1, 2)] <= lb0_rd;
                win_q[win_idx(2, 2)] <= p0_pix;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: output register, held stable while the beat is refused
    // ------------------------------------------------------------------
    logic [WIN_N-1:0][W-1:0] m_dat_q;
    logic                    m_usr_q;
    logic                    m_lst_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_vld_q <= 1'b0;
            m_dat_q <= '0;
            m_usr_q <= 1'b0;
            m_lst_q <= 1'b0;
        end else if (adv) begin
            m_vld_q <= w_meta.win && !resync;
            m_dat_q <= win_q;
            m_usr_q <= w_meta.first;
            m_lst_q <= w_meta.last;
        end
    end

    assign m00_axis_tvalid = m_vld_q;
    assign m00_axis_tdata  = m_dat_q;
    assign m00_axis_tstrb  = '1;
    assign m00_axis_tuser  = m_usr_q;
    assign m00_axis_tlast  = m_lst_q;

endmodule

// File: tb/tb_sliding_window_3x3_axis.sv
// Directed bench for sliding_window_3x3_axis on a 4x4 padded frame, 8-bit pixels.
// Latency: n/a (testbench).
// Backpressure: downstream ready driven per test (always, 1-of-3, never).
module tb_sliding_window_3x3_axis;

    localparam int W  = 8;
    localparam int PW = 4;
    localparam int PH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [W-1:0]  s_tdata = '0;
    logic          s_tuser = 1'b0;
    logic          s_tlast = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [71:0]   m_tdata;
    logic [8:0]    m_tstrb;
    logic          m_tuser;
    logic          m_tlast;
`ifdef SLIDING_WINDOW_LINE_CHECK_EN
    logic          err_line_len;
`endif

    sliding_window_3x3_axis #(
        .C_AXIS_TDATA_WIDTH (W),
        .PAD_W              (PW),
        .PAD_H              (PH)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tuser  (s_tuser),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tuser  (m_tuser),
        .m00_axis_tlast  (m_tlast)
`ifdef SLIDING_WINDOW_LINE_CHECK_EN
        ,
        .err_line_len    (err_line_len)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          in_row;
        int          in_col;
        logic [71:0] dat;
        logic        usr;
        logic        lst;
    } vec_t;

    typedef struct {
        logic [71:0] dat;
        logic        usr;
        logic        lst;
    } beat_t;

    vec_t  exp_tbl [4];
    beat_t got_q [$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    rdy_mode = 0;
    int    cyc = 0;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Downstream ready pattern, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 3 == 0);
            default: m_tready = 1'b0;
        endcase
    end

    // Output monitor: records handshakes, checks hold stability and input stall.
    logic        held_q = 1'b0;
    logic [73:0] held_v;
    always @(negedge clk) begin
        if (!resetn) begin
            held_q = 1'b0;
        end else begin
            if (held_q) begin
                check("hold_vld", m_tvalid, 1'b1);
                check("hold_beat", {m_tuser, m_tlast, m_tdata}, held_v);
            end
            if (m_tvalid && m_tready) begin
                got_q.push_back('{m_tdata, m_tuser, m_tlast});
            end
            if (m_tvalid && !m_tready) begin
                check("stall_s_rdy", s_tready, 1'b0);
                held_q = 1'b1;
                held_v = {m_tuser, m_tlast, m_tdata};
            end else begin
                held_q = 1'b0;
            end
        end
    end

    // Called and returns in the phase just after a rising edge.
    task automatic send_pixel(input logic [7:0] d, input logic u, input logic l);
        bit done;
        done = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
        end
        if (!done) fail_now("accept_timeout");
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int npix, input bit gaps, input bit extra_tl);
        int r;
        int c;
        logic [7:0] d;
        for (int p = 0; p < npix; p++) begin
            r = p / PW;
            c = p % PW;
            d = {r[3:0], c[3:0]};
            send_pixel(d, p == 0, (c == PW - 1) || (extra_tl && r == 1 && c == 2));
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 400 && got_q.size() < n; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        check({tag, "_count"}, got_q.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_beats(input string tag, input int n);
        int j;
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            j = i % 4;
            check($sformatf("%s_dat%0d_r%0dc%0d", tag, i, exp_tbl[j].in_row, exp_tbl[j].in_col),
                  got_q[i].dat, exp_tbl[j].dat);
            check($sformatf("%s_usr_lst%0d", tag, i),
                  {got_q[i].usr, got_q[i].lst}, {exp_tbl[j].usr, exp_tbl[j].lst});
        end
        got_q.delete();
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        // Windows of a 4x4 frame, pixel = {row,col}; slot 3r+c, slot 0 in the low byte.
        exp_tbl[0] = '{2, 2, 72'h22_21_20_12_11_10_02_01_00, 1'b1, 1'b0};
        exp_tbl[1] = '{2, 3, 72'h23_22_21_13_12_11_03_02_01, 1'b0, 1'b1};
        exp_tbl[2] = '{3, 2, 72'h32_31_30_22_21_20_12_11_10, 1'b0, 1'b0};
        exp_tbl[3] = '{3, 3, 72'h33_32_31_23_22_21_13_12_11, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_vld", m_tvalid, 1'b0);
        check("rst_s_rdy", s_tready, 1'b0);
        check("rst_dat", m_tdata, 72'h0);
        check("rst_usr_lst", {m_tuser, m_tlast}, 2'b00);
        check("strb", m_tstrb, 9'h1FF);
`ifdef SLIDING_WINDOW_LINE_CHECK_EN
        check("rst_err", err_line_len, 1'b0);
`endif
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // 1: one frame, no backpressure
        rdy_mode = 0;
        send_frame(16, 1'b0, 1'b0);
        wait_beats("t1", 4);
        compare_beats("t1", 4);

        // 2: downstream ready 1-of-3 cycles
        rdy_mode = 1;
        send_frame(16, 1'b0, 1'b0);
        wait_beats("t2", 4);
        compare_beats("t2", 4);
        rdy_mode = 0;

        // 3: input gaps, two back-to-back frames
        send_frame(16, 1'b1, 1'b0);
        send_frame(16, 1'b1, 1'b0);
        wait_beats("t3", 8);
        compare_beats("t3", 8);

        // 4: tuser reasserted at (row1,col2)
        send_frame(6, 1'b0, 1'b0);
        send_frame(16, 1'b0, 1'b0);
        wait_beats("t4", 4);
        compare_beats("t4", 4);

        // 5: reset pulse while a beat is held
        rdy_mode = 2;
        send_frame(11, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_held_vld", m_tvalid, 1'b1);
        check("t5_held_dat", m_tdata, exp_tbl[0].dat);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("t5_vld_after_rst", m_tvalid, 1'b0);
        check("t5_s_rdy_in_rst", s_tready, 1'b0);
        resetn = 1'b1;
        rdy_mode = 0;
        got_q.delete();
        send_frame(16, 1'b0, 1'b0);
        wait_beats("t5", 4);
        compare_beats("t5", 4);

        // 6: early tlast at col 2 of row 1
`ifdef SLIDING_WINDOW_LINE_CHECK_EN
        check("t6_err_before", err_line_len, 1'b0);
        send_frame(16, 1'b0, 1'b1);
        @(negedge clk);
        check("t6_err_set", err_line_len, 1'b1);
        repeat (10) @(negedge clk);
        check("t6_err_sticky", err_line_len, 1'b1);
        @(posedge clk);
        #1;
        reset_pulse();
        @(negedge clk);
        check("t6_err_cleared", err_line_len, 1'b0);
        @(posedge clk);
        #1;
        got_q.delete();
`else
        send_frame(16, 1'b0, 1'b1);
        wait_beats("t6", 4);
        compare_beats("t6", 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
